// File: rtl/fre_meas_ctrl_if.sv
// Control/result bundle of the gated frequency-measurement controller:
// start request, busy flag and the valid/ready result handshake.
interface fre_meas_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic             start;
    logic             busy;
    logic             fre_valid;
    logic             fre_ready;
    logic [CNT_W-1:0] fre_value;
    logic             overflow;

    modport master (
        input  start, fre_ready,
        output busy, fre_valid, fre_value, overflow
    );

    modport slave (
        output start, fre_ready,
        input  busy, fre_valid, fre_value, overflow
    );
endinterface

// File: rtl/fre_meas_ctrl.sv
// Gated frequency-measurement controller: tick-aligned gate of GATE_TICKS ticks,
// saturating rise counter, latched result on a valid/ready handshake.
// Optional macro FRE_AUTO_RESTART_EN: re-arm after each handshake for back-to-back results.
module fre_meas_ctrl #(
    parameter logic [25:0] CLK_FRE    = 26'd50_000_000,
    parameter int          GATE_TICKS = 100_000,
    parameter int          CNT_W      = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tick_10us,
    input  logic           sig_in,
    fre_meas_ctrl_if.master bus
);

    localparam int TICK_W = $clog2(GATE_TICKS) + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(GATE_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              ovf_int_q, ovf_int_d;
    logic [CNT_W-1:0]  fre_value_q, fre_value_d;
    logic              overflow_q, overflow_d;
    logic              fre_valid_q, fre_valid_d;

    logic              rise;
    logic              edge_full;
    logic [CNT_W-1:0]  edge_next;
    logic              ovf_next;

    // A rise that lands on the closing tick must still make it into the result,
    // so the incremented/saturated count is formed once and used for both paths.
    assign rise      = s2_q & ~s3_q;
    assign edge_full = &edge_cnt_q;
    assign edge_next = (rise && !edge_full) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    assign ovf_next  = ovf_int_q | (rise & edge_full);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        s1_d        = sig_in;
        s2_d        = s1_q;
        s3_d        = s2_q;
        edge_cnt_d  = edge_cnt_q;
        tick_cnt_d  = tick_cnt_q;
        ovf_int_d   = ovf_int_q;
        fre_value_d = fre_value_q;
        overflow_d  = overflow_q;
        fre_valid_d = fre_valid_q;

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                tick_cnt_d = '0;
                ovf_int_d  = 1'b0;
                if (bus.start) begin
                    state_d = S_ARM;
                end
            end

            S_ARM: begin
                // Cleared here too: with auto-restart ARM is entered straight from DONE.
                edge_cnt_d = '0;
                tick_cnt_d = '0;
                ovf_int_d  = 1'b0;
                if (tick_10us) begin
                    state_d = S_GATE;
                end
            end

            S_GATE: begin
                edge_cnt_d = edge_next;
                ovf_int_d  = ovf_next;
                if (tick_10us) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d     = S_DONE;
                        fre_value_d = edge_next;
                        overflow_d  = ovf_next;
                        fre_valid_d = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end

            S_DONE: begin
                if (fre_valid_q && bus.fre_ready) begin
                    fre_valid_d = 1'b0;
`ifdef FRE_AUTO_RESTART_EN
                    state_d     = S_ARM;
`else
                    state_d     = S_IDLE;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: asynchronous reset clears every flop, so an abort never leaves a partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            edge_cnt_q  <= '0;
            tick_cnt_q  <= '0;
            ovf_int_q   <= 1'b0;
            fre_value_q <= '0;
            overflow_q  <= 1'b0;
            fre_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            edge_cnt_q  <= edge_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            ovf_int_q   <= ovf_int_d;
            fre_value_q <= fre_value_d;
            overflow_q  <= overflow_d;
            fre_valid_q <= fre_valid_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.fre_valid = fre_valid_q;
    assign bus.fre_value = fre_value_q;
    assign bus.overflow  = overflow_q;

    a_cfg_sane: assert property (@(posedge clk) disable iff (rst)
        (CLK_FRE != 26'd0) && (GATE_TICKS >= 1) && ($bits(bus.fre_value) == CNT_W));

endmodule

// File: tb/tb_fre_meas_ctrl.sv
// Bench for fre_meas_ctrl: a 32-bit and a 4-bit instance share stimulus; results are
// checked against a table and against a gate-window model built from recorded inputs.
`timescale 1ns/1ps
module tb_fre_meas_ctrl;

    localparam int GATE_TICKS = 4;
    localparam int TICK_P     = 10;
    localparam int HIST       = 8192;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic tick_10us = 1'b0;
    logic sig_in    = 1'b0;
    logic start     = 1'b0;
    logic fre_ready = 1'b0;

    fre_meas_ctrl_if #(.CNT_W(32)) bus_w ();
    fre_meas_ctrl_if #(.CNT_W(4))  bus_n ();

    assign bus_w.start     = start;
    assign bus_w.fre_ready = fre_ready;
    assign bus_n.start     = start;
    assign bus_n.fre_ready = fre_ready;

    fre_meas_ctrl #(.CLK_FRE(26'd50_000_000), .GATE_TICKS(GATE_TICKS), .CNT_W(32)) dut_w (
        .clk(clk), .rst(rst), .tick_10us(tick_10us), .sig_in(sig_in), .bus(bus_w.master));

    fre_meas_ctrl #(.CLK_FRE(26'd50_000_000), .GATE_TICKS(GATE_TICKS), .CNT_W(4)) dut_n (
        .clk(clk), .rst(rst), .tick_10us(tick_10us), .sig_in(sig_in), .bus(bus_n.master));

    always #5 clk = ~clk;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   edge_n     = 0;
    int   sig_period = 4;   // >0 square wave period, 0 held low, <0 random
    logic sig_h  [HIST];
    logic tick_h [HIST];

    // Record the inputs each DUT edge sees; the model works from this history.
    initial forever begin
        @(posedge clk);
        edge_n = edge_n + 1;
        if (edge_n < HIST) begin
            sig_h[edge_n]  = sig_in;
            tick_h[edge_n] = tick_10us;
        end
    end

    initial begin
        int gen_cyc;
        gen_cyc = 0;
        forever begin
            @(negedge clk);
            gen_cyc   = gen_cyc + 1;
            tick_10us = ((gen_cyc % TICK_P) == 0);
            if (sig_period > 0)       sig_in = ((gen_cyc / (sig_period / 2)) % 2) == 1;
            else if (sig_period == 0) sig_in = 1'b0;
            else                      sig_in = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    // Gate opens on the first tick after the arm edge and closes on the GATE_TICKS-th
    // tick after that. A rise reaches the counter 2 edges after sig_in is sampled high
    // following a low sample; rises between opening (exclusive) and closing (inclusive) count.
    function automatic void model_meas(input int arm_edge, output int close_edge,
                                       output longint unsigned rises);
        int open_edge = -1;
        int ticks     = 0;
        close_edge = -1;
        rises      = 0;
        for (int m = arm_edge + 1; m <= edge_n && m < HIST; m++) begin
            if (open_edge < 0) begin
                if (tick_h[m]) open_edge = m;
            end else begin
                if (m >= 4 && sig_h[m-2] && !sig_h[m-3]) rises++;
                if (tick_h[m]) begin
                    ticks++;
                    if (ticks == GATE_TICKS) begin
                        close_edge = m;
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic check_result(input string tag, input longint unsigned exp);
        check({tag, " value32"}, 64'(bus_w.fre_value), exp);
        check({tag, " ovf32"},   64'(bus_w.overflow), 64'd0);
        check({tag, " value4"},  64'(bus_n.fre_value), (exp > 15) ? 64'd15 : exp);
        check({tag, " ovf4"},    64'(bus_n.overflow), (exp >= 16) ? 64'd1 : 64'd0);
    endtask

    // Waits for fre_valid; returns the edge it appeared after, or -1 on timeout.
    task automatic wait_valid(input string tag, output int v_edge);
        bit seen = 0;
        v_edge = -1;
        for (int i = 0; i < 300; i++) begin
            if (bus_w.fre_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " valid_seen"}, 64'(seen), 64'd1);
        if (seen) v_edge = edge_n;
    endtask

    task automatic run_row(input string tag, input int period, input bit use_tab,
                           input longint unsigned exp_tab, input int rdy_delay);
        int a, v, close_e;
        longint unsigned rises, exp;
        logic [31:0] held;
        sig_period = period;
        repeat ($urandom_range(2, 12)) @(negedge clk);
        start = 1'b1;
        a     = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " busy_after_start"}, 64'(bus_w.busy), 64'd1);
        wait_valid(tag, v);
        if (v < 0) return;
        model_meas(a, close_e, rises);
        check({tag, " valid_edge"}, 64'(v), 64'(close_e));
        check({tag, " valid4"}, 64'(bus_n.fre_valid), 64'd1);
        exp = use_tab ? exp_tab : rises;
        check_result(tag, exp);
        held = bus_w.fre_value;
        for (int i = 0; i < rdy_delay; i++) begin
            if (rdy_delay >= 4 && i == rdy_delay / 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, " hold_valid"}, 64'(bus_w.fre_valid), 64'd1);
            check({tag, " hold_busy"},  64'(bus_w.busy), 64'd1);
            check({tag, " hold_value"}, 64'(bus_w.fre_value), 64'(held));
        end
        fre_ready = 1'b1;
        @(negedge clk);
        fre_ready = 1'b0;
        check({tag, " valid_dropped"}, 64'(bus_w.fre_valid), 64'd0);
        check({tag, " idle_busy"},     64'(bus_w.busy), 64'd0);
        repeat (3) @(negedge clk);
        check({tag, " still_idle"},    64'(bus_w.busy), 64'd0);
        check({tag, " value_kept"},    64'(bus_w.fre_value), exp);
    endtask

    typedef struct {
        int              period;
        bit              use_tab;
        longint unsigned exp_rises;
        int              rdy_delay;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   a, v, close_e;
        longint unsigned rises;

        vecs[0] = '{period: 4,  use_tab: 1, exp_rises: 10, rdy_delay: 0};
        vecs[1] = '{period: 2,  use_tab: 1, exp_rises: 20, rdy_delay: 0};
        vecs[2] = '{period: 0,  use_tab: 1, exp_rises: 0,  rdy_delay: 3};
        vecs[3] = '{period: 8,  use_tab: 1, exp_rises: 5,  rdy_delay: 20};
        vecs[4] = '{period: 40, use_tab: 1, exp_rises: 1,  rdy_delay: 1};
        vecs[5] = '{period: -1, use_tab: 0, exp_rises: 0,  rdy_delay: 2};
        vecs[6] = '{period: -1, use_tab: 0, exp_rises: 0,  rdy_delay: 0};
        vecs[7] = '{period: -1, use_tab: 0, exp_rises: 0,  rdy_delay: 6};

        repeat (3) @(negedge clk);
        check("rst busy",      64'(bus_w.busy), 64'd0);
        check("rst valid",     64'(bus_w.fre_valid), 64'd0);
        check("rst value",     64'(bus_w.fre_value), 64'd0);
        check("rst ovf",       64'(bus_w.overflow), 64'd0);
        check("rst value4",    64'(bus_n.fre_value), 64'd0);
        check("rst busy4",     64'(bus_n.busy), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

`ifdef FRE_AUTO_RESTART_EN
        sig_period = 4;
        fre_ready  = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = edge_n + 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            string tag;
            tag = $sformatf("auto%0d", k);
            check({tag, " busy"}, 64'(bus_w.busy), 64'd1);
            wait_valid(tag, v);
            if (v < 0) break;
            model_meas(a, close_e, rises);
            check({tag, " valid_edge"}, 64'(v), 64'(close_e));
            check({tag, " model_rises"}, 64'(bus_w.fre_value), rises);
            check_result(tag, 10);
            a = edge_n + 1;
            @(negedge clk);
            check({tag, " valid_dropped"}, 64'(bus_w.fre_valid), 64'd0);
            check({tag, " busy_kept"},     64'(bus_w.busy), 64'd1);
        end
`else
        for (int i = 0; i < 8; i++) begin
            run_row($sformatf("row%0d", i), vecs[i].period, vecs[i].use_tab,
                    vecs[i].exp_rises, vecs[i].rdy_delay);
        end

        // Reset 15 clk into the gate, then a fresh measurement must be complete.
        sig_period = 4;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tick_h[edge_n]) break;
        end
        repeat (15) @(negedge clk);
        check("pre_rst busy", 64'(bus_w.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst busy",   64'(bus_w.busy), 64'd0);
        check("midrst valid",  64'(bus_w.fre_valid), 64'd0);
        check("midrst value",  64'(bus_w.fre_value), 64'd0);
        check("midrst ovf4",   64'(bus_n.overflow), 64'd0);
        check("midrst value4", 64'(bus_n.fre_value), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_row("rst_rerun", 4, 1, 10, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
